// File: rtl/pingpong_filler_if.sv
// Handshake/bus bundle between the JTAG shift path, the ping-pong buffer port B
// and the consumer-side swap control.
interface pingpong_filler_if #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 512
);
    localparam int AW = $clog2(nrOfEntries);

    logic                shiftEnable;
    logic                dataBit;
    logic                flush;
    logic                consumerReady;
    logic [AW-1:0]       addressB;
    logic [bitwidth-1:0] dataInB;
    logic                writeEnableB;
    logic                switch;
    logic [AW:0]         validWords;
    logic                busy;
    logic                overflow;

    modport master (
        output shiftEnable, dataBit, flush, consumerReady,
        input  addressB, dataInB, writeEnableB, switch, validWords, busy, overflow
    );

    modport slave (
        input  shiftEnable, dataBit, flush, consumerReady,
        output addressB, dataInB, writeEnableB, switch, validWords, busy, overflow
    );
endinterface

// File: rtl/pingpong_filler.sv
// Assembles a serial bit stream LSB-first into words, writes them into one half of a
// ping-pong buffer, and hands the half over to the consumer when full or flushed.
module pingpong_filler #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 512
) (
    input  logic              clock,
    input  logic              reset,
    pingpong_filler_if.slave  bus
);
    localparam int AW  = $clog2(nrOfEntries);
    localparam int BCW = $clog2(bitwidth);
    localparam logic [AW:0]  LAST_IDX = (AW+1)'(nrOfEntries - 1);
    localparam logic [BCW:0] FULL_BITS = (BCW+1)'(bitwidth);

    typedef enum logic {COLLECT, SWITCH_WAIT} state_t;

    state_t              state_q, state_d;
    logic [bitwidth-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]      bitcnt_q, bitcnt_d;
    logic [AW:0]         widx_q, widx_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [bitwidth-1:0] data_q, data_d;
    logic                we_q, we_d;
    logic                sw_q, sw_d;
    logic [AW:0]         vw_q, vw_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic [bitwidth-1:0] word_w;
    logic [BCW:0]        nbits;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        widx_d   = widx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        sw_d     = 1'b0;
        vw_d     = vw_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        word_w   = shreg_q;
        nbits    = {1'b0, bitcnt_q};

        unique case (state_q)
            COLLECT: begin
                // A coincident bit is absorbed before flush is considered.
                if (bus.shiftEnable) begin
                    word_w[bitcnt_q] = bus.dataBit;
                    nbits            = nbits + 1'b1;
                end
                if (nbits == FULL_BITS || (bus.flush && nbits != '0)) begin
                    we_d     = 1'b1;
                    addr_d   = widx_q[AW-1:0];
                    data_d   = word_w;
                    widx_d   = widx_q + 1'b1;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    if (bus.flush || widx_q == LAST_IDX) begin
                        state_d = SWITCH_WAIT;
                        busy_d  = 1'b1;
                    end
                end else begin
                    shreg_d  = word_w;
                    bitcnt_d = nbits[BCW-1:0];
                    if (bus.flush && widx_q != '0) begin
                        state_d = SWITCH_WAIT;
                        busy_d  = 1'b1;
                    end
                end
            end
            SWITCH_WAIT: begin
                // The half is closed; anything shifted now has nowhere to go.
                if (bus.shiftEnable) ovf_d = 1'b1;
                if (bus.consumerReady) begin
                    sw_d     = 1'b1;
                    vw_d     = widx_q;
                    widx_d   = '0;
                    bitcnt_d = '0;
                    shreg_d  = '0;
                    state_d  = COLLECT;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= COLLECT;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            widx_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            sw_q     <= 1'b0;
            vw_q     <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            widx_q   <= widx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            sw_q     <= sw_d;
            vw_q     <= vw_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.addressB     = addr_q;
    assign bus.dataInB      = data_q;
    assign bus.writeEnableB = we_q;
    assign bus.switch       = sw_q;
    assign bus.validWords   = vw_q;
    assign bus.busy         = busy_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: doc/pingpong_filler.md
PINGPONG_FILLER -- requirements
Module: pingpong_filler

Interface
REQ-001 SHALL have parameter bitwidth, default 32, word width written into the ping-pong buffer.
REQ-002 SHALL have parameter nrOfEntries, default 512, words per buffer half; address width AW = clog2(nrOfEntries).
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port shiftEnable  input  1  dataBit is valid this cycle.
REQ-006 SHALL have port dataBit  input  1  serial data bit from the JTAG shift path.
REQ-007 SHALL have port flush  input  1  pulse; close the current half early.
REQ-008 SHALL have port consumerReady  input  1  consumer has finished the other half; a switch is permitted.
REQ-009 SHALL have port addressB  output  AW  write address into the buffer port B.
REQ-010 SHALL have port dataInB  output  bitwidth  write data into the buffer port B.
REQ-011 SHALL have port writeEnableB  output  1  one-cycle write strobe.
REQ-012 SHALL have port switch  output  1  one-cycle buffer-swap pulse.
REQ-013 SHALL have port validWords  output  AW+1  word count of the half most recently handed over.
REQ-014 SHALL have port busy  output  1  high while in SWITCH_WAIT.
REQ-015 SHALL have port overflow  output  1  sticky; input bits were dropped.

Function
REQ-016 SHALL use two states: COLLECT and SWITCH_WAIT; all outputs registered.
REQ-017 In COLLECT, each cycle with shiftEnable=1 SHALL store dataBit LSB-first (the k-th bit of a word lands in bit k) and increment the bit counter.
REQ-018 On receipt of bit bitwidth-1, SHALL assert writeEnableB for exactly the next cycle, with dataInB = the assembled word and addressB = the word index.
REQ-019 Bit reception SHALL continue without gaps during the write cycle; the bit counter wraps to 0.
REQ-020 The word index SHALL increment after each write; the write to index nrOfEntries-1 SHALL move the FSM to SWITCH_WAIT.
REQ-021 Flush in COLLECT with a partial word SHALL write that word zero-padded in its upper bits, then enter SWITCH_WAIT.
REQ-022 Flush in COLLECT with whole words only and no partial bits SHALL enter SWITCH_WAIT without a write.
REQ-023 Flush in COLLECT with zero words and zero bits SHALL be ignored.
REQ-024 If shiftEnable and flush coincide, the bit SHALL be taken first; if that bit completes a word, this is a normal write followed by SWITCH_WAIT.
REQ-025 In SWITCH_WAIT with consumerReady=1, the next cycle SHALL have: switch=1 for one cycle; validWords = words written this half (1..nrOfEntries); word index and bit counter = 0; state = COLLECT.
REQ-026 Bits arriving in the switch cycle SHALL be accepted into the new half.
REQ-027 In SWITCH_WAIT, shiftEnable=1 SHALL discard the bit and set overflow; flush SHALL be ignored.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 Reset SHALL force state COLLECT and all outputs, counters and the shift register to 0, including mid-word and in SWITCH_WAIT.
REQ-030 Reset SHALL discard any partial word.

Verification
REQ-031 Stimulus: shift 0xFFFFFFF0 then 0x00000001, consumerReady=0. Response: writes addr0=0xFFFFFFF0 and addr1=0x00000001, each one cycle after its 32nd bit; no switch.
REQ-032 Stimulus: shift 8 bits of 0xA5, then flush, with consumerReady=1. Response: write addr0=0x000000A5, then a switch pulse with validWords=1.
REQ-033 Stimulus: shift 512 words (word n = n), consumerReady=0. Response: busy=1 after the addr511 write and no switch; on raising consumerReady, a one-cycle switch with validWords=512; next word goes to addr0.
REQ-034 Stimulus: 3 bits while busy=1. Response: overflow=1, no write; overflow stays high after the switch until reset.
REQ-035 Stimulus: 16 bits, reset, then 0x12345678. Response: a single write, addr0=0x12345678.
REQ-036 Stimulus: flush right after reset. Response: no write, no switch, busy stays 0.
